seq_detect_param: RTL and testbench

- Parametrised serial pattern detector; next generation of the fixed two-bit "11" Mealy detector.
- Detects a runtime-loadable PAT_W-bit pattern on a qualified serial bit stream.
- Supports overlapping and non-overlapping match modes, and Mealy or Moore output timing.
- Sits on serial-link and protocol-framing paths. With PAT_W=2, MEALY=1 and the reset pattern, it reproduces the legacy "11" detector.

---
 rtl/seq_detect_param_if.sv | 38 +++
 rtl/seq_detect_param.sv | 99 +++++++++
 tb/tb_seq_detect_param.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_param_if.sv
// Serial detector bus: stream, configuration and match status.
// SEQDET_MATCH_CNT_EN adds the saturating match_cnt signal.
interface seq_detect_param_if #(
   parameter int unsigned PAT_W = 4,
   parameter int unsigned CNT_W = 8
);
   logic             en;
   logic             in_vld;
   logic             in_bit;
   logic             cfg_load;
   logic [PAT_W-1:0] cfg_pattern;
   logic             cfg_overlap;
   logic             armed;
   logic             match;
`ifdef SEQDET_MATCH_CNT_EN
   logic [CNT_W-1:0] match_cnt;
`endif

   if (CNT_W == 0) begin : g_bad_cnt_w
      $error("seq_detect_param_if: CNT_W must be at least 1");
   end

   modport master (
      output en, in_vld, in_bit, cfg_load, cfg_pattern, cfg_overlap,
`ifdef SEQDET_MATCH_CNT_EN
      input  match_cnt,
`endif
      input  armed, match
   );

   modport slave (
      input  en, in_vld, in_bit, cfg_load, cfg_pattern, cfg_overlap,
`ifdef SEQDET_MATCH_CNT_EN
      output match_cnt,
`endif
      output armed, match
   );
endinterface

// File: rtl/seq_detect_param.sv
// Runtime-loadable PAT_W-bit serial pattern detector, overlap/non-overlap, Mealy/Moore.
// Optional saturating match counter under SEQDET_MATCH_CNT_EN.
module seq_detect_param #(
   parameter int unsigned PAT_W = 4,
   parameter bit          MEALY = 1'b1,
   parameter int unsigned CNT_W = 8
) (
   input logic              clk,
   input logic              rst,
   seq_detect_param_if.slave bus
);
   localparam int unsigned FILL_W = $clog2(PAT_W);
   localparam int unsigned HIST_W = PAT_W - 1;
   localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W - 1);

   if (PAT_W < 2 || PAT_W > 16 || CNT_W == 0) begin : g_bad_param
      $error("seq_detect_param: PAT_W must be 2..16 and CNT_W at least 1");
   end

   typedef enum logic [1:0] {IDLE, FILL, HUNT} phase_e;

   logic [PAT_W-1:0]  pat_q, pat_d;
   logic              overlap_q, overlap_d;
   logic [HIST_W-1:0] hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;

   phase_e            phase_c;
   logic              acc_c;
   logic              hit_c;
   logic [PAT_W-1:0]  window_c;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q     <= '1;
         overlap_q <= 1'b1;
         hist_q    <= '0;
         fill_q    <= '0;
      end else begin
         pat_q     <= pat_d;
         overlap_q <= overlap_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
      end
   end

   // Phase decode, hit detection and next-state
   always_comb begin
      pat_d     = pat_q;
      overlap_d = overlap_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      phase_c   = IDLE;

      if (bus.en) phase_c = (fill_q == FULL) ? HUNT : FILL;

      acc_c    = bus.en & bus.in_vld & ~bus.cfg_load;
      window_c = {hist_q, bus.in_bit};
      hit_c    = acc_c & (phase_c == HUNT) & (window_c == pat_q);

      if (bus.cfg_load) begin
         pat_d     = bus.cfg_pattern;
         overlap_d = bus.cfg_overlap;
         fill_d    = '0;
      end else if (!bus.en) begin
         fill_d = '0;
      end else if (acc_c) begin
         hist_d = window_c[HIST_W-1:0];
         // Non-overlap: a hit forces a full refill before the next match
         if (hit_c && !overlap_q) fill_d = '0;
         else if (fill_q != FULL) fill_d = fill_q + FILL_W'(1);
      end
   end

   assign bus.armed = (phase_c == HUNT);

   if (MEALY) begin : g_mealy
      assign bus.match = hit_c;
   end else begin : g_moore
      logic match_q;
      // Not cleared by cfg_load so a hit registered before a load still pulses
      always_ff @(posedge clk) begin
         if (rst) match_q <= 1'b0;
         else     match_q <= hit_c;
      end
      assign bus.match = match_q;
   end

`ifdef SEQDET_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || bus.cfg_load)    cnt_q <= '0;
      else if (hit_c && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
   end

   assign bus.match_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: Mealy and Moore instances share stimulus; table + random vs queue model.
module tb_seq_detect_param;
   localparam int unsigned PAT_W = 4;
   localparam int unsigned CNT_W = 2;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst;

   seq_detect_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bm ();
   seq_detect_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) br ();

   seq_detect_param #(.PAT_W(PAT_W), .MEALY(1'b1), .CNT_W(CNT_W)) dut_mealy (
      .clk(clk), .rst(rst), .bus(bm.slave));
   seq_detect_param #(.PAT_W(PAT_W), .MEALY(1'b0), .CNT_W(CNT_W)) dut_moore (
      .clk(clk), .rst(rst), .bus(br.slave));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: queue of accepted bits since the last flush, oldest first
   logic [PAT_W-1:0] m_pat;
   bit               m_ov;
   bit               m_q[$];
   bit               m_prev;
   int               m_cnt;
   bit               last_hit;

   typedef struct {
      logic en, vld, b, load;
      logic [PAT_W-1:0] pat;
      logic ov, exp_match, exp_armed;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic e, input logic v, input logic b,
                        input logic l, input logic [PAT_W-1:0] p, input logic o);
      logic [PAT_W-1:0] win;
      bit acc, full, hit;
      @(negedge clk);
      rst = r;
      bm.en = e; bm.in_vld = v; bm.in_bit = b; bm.cfg_load = l; bm.cfg_pattern = p; bm.cfg_overlap = o;
      br.en = e; br.in_vld = v; br.in_bit = b; br.cfg_load = l; br.cfg_pattern = p; br.cfg_overlap = o;
      #1;
      acc  = e & v & ~l;
      full = (m_q.size() == PAT_W - 1);
      win  = '0;
      foreach (m_q[i]) win = {win[PAT_W-2:0], m_q[i]};
      win  = {win[PAT_W-2:0], b};
      hit  = acc && full && (win == m_pat);
      chk("mealy_match", 32'(bm.match), 32'(hit));
      chk("moore_match", 32'(br.match), 32'(m_prev));
      chk("mealy_armed", 32'(bm.armed), 32'(e & full));
      chk("moore_armed", 32'(br.armed), 32'(e & full));
`ifdef SEQDET_MATCH_CNT_EN
      chk("mealy_cnt", 32'(bm.match_cnt), 32'(m_cnt));
      chk("moore_cnt", 32'(br.match_cnt), 32'(m_cnt));
`endif
      last_hit = hit;
      m_prev = r ? 1'b0 : hit;
      if (r) begin
         m_pat = '1; m_ov = 1'b1; m_q.delete(); m_cnt = 0;
      end else if (l) begin
         m_pat = p; m_ov = o; m_q.delete(); m_cnt = 0;
      end else if (!e) begin
         m_q.delete();
      end else if (acc) begin
         if (hit && m_cnt < CNT_MAX) m_cnt++;
         if (hit && !m_ov) m_q.delete();
         else begin
            m_q.push_back(b);
            if (m_q.size() > PAT_W - 1) void'(m_q.pop_front());
         end
      end
   endtask

   function automatic vec_t mk(logic en, logic vld, logic b, logic load,
                               logic [PAT_W-1:0] pat, logic ov, logic m, logic a);
      vec_t v;
      v.en = en; v.vld = vld; v.b = b; v.load = load; v.pat = pat; v.ov = ov;
      v.exp_match = m; v.exp_armed = a;
      return v;
   endfunction

   initial begin
      int hits;
      // Reset pattern 1111, overlap: five ones
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 0));
      for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 1, 1));
      // Load 1011 overlap (bit discarded), stream 1,0,1,1,0,1,1
      tbl.push_back(mk(1, 1, 1, 1, 4'hB, 1, 0, 1));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 1, 1));
      tbl.push_back(mk(1, 1, 0, 0, 4'h0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 1, 1));
      // Non-overlap: same stream, only bit 4 matches
      tbl.push_back(mk(1, 0, 0, 1, 4'hB, 0, 0, 1));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 1, 1));
      tbl.push_back(mk(1, 1, 0, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 0));
      // Valid gap is transparent
      tbl.push_back(mk(1, 0, 0, 1, 4'hB, 1, 0, 1));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 4'h0, 0, 0, 0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 1, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 1, 1));
      // Enable drop flushes history
      tbl.push_back(mk(1, 0, 0, 1, 4'hB, 1, 0, 1));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 0));
      // Load on bit 3 discards it; four fresh bits needed
      tbl.push_back(mk(1, 0, 0, 1, 4'hB, 1, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 1, 4'hB, 1, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 4'h0, 0, 1, 1));

      // Raw reset, then model starts from the reset state
      rst = 1'b1;
      bm.en = 0; bm.in_vld = 0; bm.in_bit = 0; bm.cfg_load = 0; bm.cfg_pattern = '0; bm.cfg_overlap = 0;
      br.en = 0; br.in_vld = 0; br.in_bit = 0; br.cfg_load = 0; br.cfg_pattern = '0; br.cfg_overlap = 0;
      repeat (2) @(negedge clk);
      m_pat = '1; m_ov = 1'b1; m_q.delete(); m_prev = 1'b0; m_cnt = 0;

      cycle(0, 1, 0, 0, 0, '0, 0);
      chk("reset_armed", 32'(bm.armed), 32'd0);
      chk("reset_mealy_match", 32'(bm.match), 32'd0);
      chk("reset_moore_match", 32'(br.match), 32'd0);

      foreach (tbl[i]) begin
         cycle(0, tbl[i].en, tbl[i].vld, tbl[i].b, tbl[i].load, tbl[i].pat, tbl[i].ov);
         chk($sformatf("tbl%0d_match", i), 32'(bm.match), 32'(tbl[i].exp_match));
         chk($sformatf("tbl%0d_armed", i), 32'(bm.armed), 32'(tbl[i].exp_armed));
         chk($sformatf("tbl%0d_model", i), 32'(last_hit), 32'(tbl[i].exp_match));
      end

      // Reset arriving on a hitting bit: Mealy pulses now, everything clear next cycle
      cycle(0, 1, 1, 0, 0, '0, 0);
      cycle(0, 1, 1, 1, 0, '0, 0);
      cycle(1, 1, 1, 1, 0, '0, 0);
      chk("rst_cycle_mealy_match", 32'(bm.match), 32'd1);
      cycle(0, 1, 1, 1, 0, '0, 0);
      chk("post_rst_armed", 32'(bm.armed), 32'd0);
      chk("post_rst_mealy_match", 32'(bm.match), 32'd0);
      chk("post_rst_moore_match", 32'(br.match), 32'd0);

      // Randomised traffic against the model
      for (int i = 0; i < 2000; i++) begin
         logic r, e, v, b, l, o;
         logic [PAT_W-1:0] p;
         r = ($urandom_range(0, 299) == 0);
         e = ($urandom_range(0, 9) != 0);
         v = ($urandom_range(0, 4) != 0);
         b = ($urandom_range(0, 2) != 0);
         l = ($urandom_range(0, 39) == 0);
         p = PAT_W'($urandom);
         o = 1'($urandom);
         cycle(r, e, v, b, l, p, o);
      end

`ifdef SEQDET_MATCH_CNT_EN
      // Counter saturation with pattern 1111 and eight ones
      cycle(1, 0, 0, 0, 0, '0, 0);
      cycle(0, 1, 0, 0, 1, 4'hF, 1);
      hits = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1, 1, 1, 0, '0, 0);
         hits += int'(bm.match);
      end
      cycle(0, 1, 0, 0, 0, '0, 0);
      chk("cnt_hits", 32'(hits), 32'd5);
      chk("cnt_saturated", 32'(bm.match_cnt), 32'd3);
      cycle(0, 1, 0, 0, 1, 4'hF, 1);
      cycle(0, 1, 0, 0, 0, '0, 0);
      chk("cnt_cleared_by_load", 32'(bm.match_cnt), 32'd0);
`else
      hits = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
